// File: rtl/pixie_dma_scheduler.sv
// pixie_dma_scheduler: CDP1861-style scanline/frame sequencer for the Pixie
// display path. Counts 1802 machine cycles into lines and frames, drives the
// DMAO/INT/EF handshakes and turns DMA-out bytes into frame-buffer writes.
// The interrupt output is named intr because int is a reserved word.
module pixie_dma_scheduler #(
  parameter int LINE_CYCLES    = 14,
  parameter int FRAME_LINES    = 262,
  parameter int DISP_START     = 64,
  parameter int DISP_LINES     = 128,
  parameter int BYTES_PER_LINE = 8,
  parameter int DMA_START      = 2,
  parameter int INT_LEAD       = 2,
  parameter int EFX_LEAD       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic [1:0] sc,
  input  logic       disp_on,
  input  logic       disp_off,
  input  logic [7:0] data,
  output logic       dmao,
  output logic       intr,
  output logic       efx,
  output logic [9:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_wr_en,
  output logic [8:0] line,
  output logic       frame_start
);

  // state | meaning
  // IDLE  | no DMA in progress on this line
  // REQ   | dmao asserted, each DMA tick captures one byte
  // DONE  | all bytes of the line captured, waiting for end of line
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dma_state_t;

  localparam int            CW        = (LINE_CYCLES > 1) ? $clog2(LINE_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(LINE_CYCLES - 1);
  localparam logic [CW-1:0] CYC_DMA   = CW'(DMA_START);
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);
  localparam logic [8:0]    LINE_LAST = 9'(FRAME_LINES - 1);
  localparam logic [8:0]    ACT_LO    = 9'(DISP_START);
  localparam logic [8:0]    ACT_HI    = 9'(DISP_START + DISP_LINES - 1);
  localparam logic [8:0]    INT_LO    = 9'(DISP_START - INT_LEAD);
  localparam logic [8:0]    PRE_HI    = 9'(DISP_START - 1);
  localparam logic [8:0]    EFA_LO    = 9'(DISP_START - EFX_LEAD);
  localparam logic [8:0]    EFB_LO    = 9'(DISP_START + DISP_LINES - EFX_LEAD);
  localparam logic [6:0]    ACT_OFS   = 7'(DISP_START);
  localparam logic [3:0]    BC_LAST   = 4'(BYTES_PER_LINE - 1);

  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_nxt;
  logic          cyc_wrap;
  logic [8:0]    line_nxt;
  logic          disp_en;
  logic          disp_en_nxt;
  logic          line_active;
  logic          act_nxt;
  logic          int_nxt;
  logic          efx_nxt;
  logic [6:0]    active_line;
  logic          capture;
  logic [3:0]    bc;
  dma_state_t    state;

  assign cyc_wrap    = (cyc == CYC_LAST);
  assign cyc_nxt     = cyc_wrap ? '0 : cyc + CYC_ONE;
  assign line_nxt    = cyc_wrap ? ((line == LINE_LAST) ? 9'd0 : line + 9'd1) : line;
  // disp_off has priority when both strobes land on the same tick
  assign disp_en_nxt = disp_off ? 1'b0 : (disp_on | disp_en);
  // flags are computed from the post-tick line so they move together with line
  assign act_nxt     = disp_en_nxt && (line_nxt >= ACT_LO) && (line_nxt <= ACT_HI);
  assign int_nxt     = disp_en_nxt && (line_nxt >= INT_LO) && (line_nxt <= PRE_HI);
  assign efx_nxt     = ((line_nxt >= EFA_LO) && (line_nxt <= PRE_HI)) ||
                       ((line_nxt >= EFB_LO) && (line_nxt <= ACT_HI));
  assign active_line = line[6:0] - ACT_OFS;
  assign capture     = (sc == 2'b10);

  // Cycle/line counters, display enable and the line-derived handshake flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc         <= '0;
      line        <= 9'd0;
      disp_en     <= 1'b0;
      line_active <= 1'b0;
      intr        <= 1'b0;
      efx         <= 1'b0;
      frame_start <= 1'b0;
    end else if (clk_enable) begin
      cyc         <= cyc_nxt;
      line        <= line_nxt;
      disp_en     <= disp_en_nxt;
      intr        <= int_nxt;
      efx         <= efx_nxt;
      frame_start <= cyc_wrap && (line == LINE_LAST);
      if (cyc_wrap) begin
        line_active <= act_nxt;
      end
    end
  end

  // DMA-out sequencer: request window, byte capture and write command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bc        <= 4'd0;
      dmao      <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= 10'd0;
      mem_data  <= 8'd0;
    end else if (clk_enable) begin
      mem_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          // disp_en is also required so a disable just before DMA_START
          // does not produce a one-tick dmao glitch
          if (line_active && disp_en && (cyc == CYC_DMA)) begin
            state <= REQ;
            dmao  <= 1'b1;
            bc    <= 4'd0;
          end
        end
        REQ: begin
          if (!disp_en) begin
            state <= IDLE;
            dmao  <= 1'b0;
          end else begin
            if (capture) begin
              mem_wr_en <= 1'b1;
              mem_addr  <= {active_line, bc[2:0]};
              mem_data  <= data;
              bc        <= bc + 4'd1;
            end
            if (cyc_wrap) begin
              state <= IDLE;
              dmao  <= 1'b0;
            end else if (capture && (bc == BC_LAST)) begin
              state <= DONE;
              dmao  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (cyc_wrap) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          dmao  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pixie_dma_scheduler.md
# pixie_dma_scheduler

Frame/line sequencer for the CDP1861-compatible Pixie display path. It counts 1802 machine cycles into scanlines and frames and raises the CPU-side handshakes: DMAO requests, INT ahead of the active window, and the EFx flag. It captures DMA-out bytes and issues frame-buffer write commands on port A. It runs entirely in the CPU bus clock domain and has no video-clock logic.

## Interface
Parameters:
- LINE_CYCLES, 14: machine cycles per scanline.
- FRAME_LINES, 262: scanlines per frame.
- DISP_START, 64: first active display line.
- DISP_LINES, 128: active lines per frame. Must be ≤128, because the frame buffer holds 128×8 bytes.
- BYTES_PER_LINE, 8: DMA bytes per active line. Fixed at 8.
- DMA_START, 2: cycle within the line at which DMAO asserts.
- INT_LEAD, 2: number of lines before DISP_START during which INT is asserted.
- EFX_LEAD, 4: number of lines before the start and before the end of the active window during which EFx is asserted.

Ports:
- clk  in  1  CPU bus clock.
- reset  in  1  asynchronous, active-high.
- clk_enable  in  1  one-clk pulse per 1802 machine cycle ("tick"); all state advances only on ticks.
- sc  in  2  1802 state code; 2'b10 = DMA cycle.
- disp_on  in  1  display-enable strobe, sampled on ticks.
- disp_off  in  1  display-disable strobe, sampled on ticks.
- data  in  8  1802 data bus during DMA-out.
- dmao  out  1  DMA-out request to the CPU.
- int  out  1  interrupt request to the CPU.
- efx  out  1  EF1 flag.
- mem_addr  out  10  frame-buffer write address, {active_line[6:0], byte[2:0]}.
- mem_data  out  8  frame-buffer write data.
- mem_wr_en  out  1  write request; the consumer qualifies it with clk_enable.
- line  out  9  current scanline, 0..FRAME_LINES-1.
- frame_start  out  1  high for one tick interval when line wraps to 0.

## Operation
- cyc counter: counts 0..LINE_CYCLES-1 and advances each tick. On wrap, line increments modulo FRAME_LINES.
- disp_en register:
  - disp_on sets it and disp_off clears it.
  - If both are asserted on the same tick, disp_off wins.
- line_active: latched at cyc==0 of each line as disp_en AND DISP_START ≤ line < DISP_START+DISP_LINES.
  - Enable or disable changes therefore take effect at the next line boundary.
  - Exception: disp_off drops dmao on the next tick; see below.
- int: registered. Equals disp_en AND line in [DISP_START-INT_LEAD, DISP_START-1].
- efx: registered and independent of disp_en. Asserted for line in [DISP_START-EFX_LEAD, DISP_START-1] or [DISP_START+DISP_LINES-EFX_LEAD, DISP_START+DISP_LINES-1].
- DMA state machine (IDLE → REQ → DONE → IDLE):
  - IDLE → REQ: when line_active and cyc==DMA_START. dmao=1; byte counter bc=0.
  - In REQ, each tick with sc==2'b10 is a capture. It sets mem_addr={active_line,bc}, mem_data=data, mem_wr_en=1, then bc++.
  - REQ → DONE: after the 8th capture (bc reaches 8). dmao=0.
  - REQ → IDLE (abort): at cyc==LINE_CYCLES-1 with bc<8, or when disp_en clears. dmao=0, and the remaining bytes of the line are not written.
  - DONE → IDLE: at cyc==LINE_CYCLES-1.
  - DMA ticks (sc==2'b10) that arrive outside REQ are ignored, with no write.
- active_line = line − DISP_START, truncated to 7 bits.

## Timing
- All outputs are registered and change only on tick clks.
- Reset values, applied asynchronously: dmao=0, int=0, efx=0, mem_wr_en=0, mem_addr=0, mem_data=0, line=0, frame_start=0. Internal state: cyc=0, disp_en=0, state=IDLE, bc=0.
- dmao rises at the tick where cyc==DMA_START and falls at the tick of the 8th capture.
- Write timing:
  - mem_wr_en is high for exactly one tick interval after each capture.
  - The write commits on the next tick: frame-buffer enable = clk_enable & mem_wr_en.
  - mem_addr and mem_data hold their value until the next capture.
- Write latency: data sampled at tick N is written at tick N+1.
- frame_start coincides with line==0 and cyc==0. int and efx update on the same tick as line.
- Reset deasserted mid-frame: the frame restarts at line 0. No writes are pending.

## Test plan
- Reset, then disp_on, then run a full frame with sc==2'b10 during every dmao window → exactly 1024 writes; first address 0x000 at line 64, last address 0x3FF at line 191.
- Per-line timing, disp enabled: int=1 only on lines 62–63; efx=1 only on lines 60–63 and 188–191; frame_start every 262×14 ticks.
- Supply only 5 DMA ticks on line 64 → addresses 0x000–0x004 written; dmao falls at cyc 13; line 65 starts at 0x008.
- disp_on and disp_off on the same tick → display stays off; dmao=0 and int=0 for the whole frame; efx still toggles.
- disp_off during REQ, after 3 captures → dmao=0 on the next tick; no further writes; the next frame writes nothing.
- Assert reset while in REQ at line 100 → all outputs 0 immediately; after release, line counts from 0 and no write is issued until line 64.
